ili_spi_tx: RTL and testbench
=============================

ILI_SPI_TX -- requirements
Module: ili_spi_tx

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning the number of bits per SPI word.
REQ-002 The block SHALL have parameter CLK_DIV, default 2, meaning the number of clk cycles per SCLK half-period, legal range 1..255.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, with ports as follows.
REQ-004 clk  input  1  system clock; all logic is on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 send  input  1  transfer request strobe from the init/command controller.
REQ-007 data  input  DW  word to transmit; sampled only when a request is accepted.
REQ-008 dc_in  input  1  data/command select for the word; 0 = command, 1 = data.
REQ-009 busy  output  1  high from the cycle after acceptance through the done cycle.
REQ-010 done  output  1  one-cycle pulse when a word has completed.
REQ-011 cs  output  1  ILI9341 chip select, active low.
REQ-012 dc  output  1  ILI9341 D/CX line.
REQ-013 sclk  output  1  SPI clock, mode 0 (idle low; the panel samples on the rising edge).
REQ-014 mosi  output  1  SPI data, MSB first.

Function
REQ-015 All outputs SHALL be registered, with no combinational path from inputs to outputs.
REQ-016 The block SHALL implement the FSM states IDLE, SETUP, SCK_HI, SCK_LO, HOLD and DONE, driven by a half-period counter and a bit counter.
REQ-017 IDLE: cs=1, sclk=0, busy=0, done=0; mosi and dc SHALL hold their last values.
REQ-018 A request SHALL be accepted only when send=1 in IDLE; data and dc_in are latched, and the next state is SETUP.
REQ-019 send while not in IDLE SHALL be ignored, with no queueing and no effect on the transfer in progress.
REQ-020 SETUP: cs=0, dc=latched dc_in, mosi=data[DW-1], sclk=0, lasting CLK_DIV cycles, then SCK_HI.
REQ-021 SCK_HI: sclk=1 for CLK_DIV cycles, with mosi stable; after it, the next state is SCK_LO if bits remain, else HOLD.
REQ-022 SCK_LO: sclk=0 for CLK_DIV cycles; mosi SHALL advance to the next lower bit in the first cycle of SCK_LO, then the next state is SCK_HI.
REQ-023 Each word SHALL produce exactly DW rising edges on sclk; mosi SHALL change only while sclk=0.
REQ-024 HOLD: sclk=0, cs=0 for CLK_DIV cycles, then DONE.
REQ-025 DONE (1 cycle): cs=1, done=1, busy=1; the next state is IDLE.
REQ-026 Latency: with acceptance at cycle 0, busy SHALL be high during cycles 1..N and done SHALL be high at cycle N, where N = 2*DW*CLK_DIV + CLK_DIV + 1 (35 for the defaults).
REQ-027 cs SHALL be high for at least 2 consecutive cycles (DONE + IDLE) between consecutive words.
REQ-028 dc SHALL remain constant while cs=0.
REQ-029 Changes to data or dc_in after acceptance SHALL NOT affect the word being sent.
REQ-030 The counters SHALL be wide enough for DW up to 16 and CLK_DIV up to 255, with no wrap during a transfer.

Reset
REQ-031 While rst=1 at a clk edge, the block SHALL go to IDLE with cs=1, dc=1, sclk=0, mosi=0, busy=0, done=0, and both counters cleared.
REQ-032 rst asserted mid-transfer SHALL abort the word: cs rises at the next edge, no done pulse is produced, and no further sclk edges occur.
REQ-033 send coincident with rst SHALL be ignored.
REQ-034 The first acceptance SHALL be possible in the first cycle after rst is deasserted.

Verification
REQ-035 Reset then single command: send=1 for 1 cycle with data=8'h2A, dc_in=0 -> 8 sclk rising edges sampling mosi 0,0,1,0,1,0,1,0; dc=0 while cs=0; done at cycle 35 after acceptance; busy high for exactly 35 cycles.
REQ-036 Data word with CLK_DIV=1: data=8'hFF, dc_in=1 -> mosi=1 at all 8 rising edges; dc=1; done at cycle 18 (2*8*1+1+1).
REQ-037 Back-to-back: send held high continuously with 8'h11 then 8'h22 -> two complete words; cs high for exactly 2 cycles between them; the second word is latched in the IDLE cycle after DONE.
REQ-038 Ignored request: pulse send with 8'h00 at cycle 10 of an 8'hA5 transfer -> the transfer completes as A5; no second word follows.
REQ-039 Mid-transfer reset: rst=1 for 1 cycle during the 4th SCK_HI -> cs=1, sclk=0, busy=0 at the next edge; no done pulse; a new send is accepted the cycle after rst falls.
REQ-040 Input hold: change data and dc_in every cycle after acceptance of 8'h3C, dc_in=1 -> the transmitted bits are 0,0,1,1,1,1,0,0 and dc stays 1.

Source files
------------

// File: rtl/ili_spi_tx.sv
// ILI9341 SPI word transmitter: mode-0 serialiser with chip select and D/CX
// handling for one DW-bit word per request.
module ili_spi_tx #(
  parameter int unsigned DW      = 8,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          send,
  input  logic [DW-1:0] data,
  input  logic          dc_in,
  output logic          busy,
  output logic          done,
  output logic          cs,
  output logic          dc,
  output logic          sclk,
  output logic          mosi
);

  // Half-period counter covers CLK_DIV up to 255; bit counter covers DW up to 16.
  localparam int unsigned CW = 8;
  localparam int unsigned BW = 5;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DW - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SCK_HI,
    ST_SCK_LO,
    ST_HOLD,
    ST_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DW-1:0] shreg_q, shreg_d;
  logic          cs_q, cs_d;
  logic          dc_q, dc_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          phase_end;
  logic [DW-1:0] shreg_shl;

  assign phase_end = (cnt_q == CNT_LAST);
  assign shreg_shl = shreg_q << 1;

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so every pin comes straight from a flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    cs_d    = cs_q;
    dc_d    = dc_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cs_d   = 1'b1;
        sclk_d = 1'b0;
        busy_d = 1'b0;
        if (send) begin
          state_d = ST_SETUP;
          shreg_d = data;
          cnt_d   = '0;
          bit_d   = '0;
          cs_d    = 1'b0;
          dc_d    = dc_in;
          mosi_d  = data[DW-1];
          busy_d  = 1'b1;
        end
      end

      ST_SETUP: begin
        if (phase_end) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          state_d = ST_SCK_HI;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_SCK_HI: begin
        if (phase_end) begin
          cnt_d  = '0;
          sclk_d = 1'b0;
          if (bit_q == BIT_LAST) begin
            state_d = ST_HOLD;
          end else begin
            // Next bit goes out together with the falling sclk edge.
            state_d = ST_SCK_LO;
            bit_d   = bit_q + BW'(1);
            shreg_d = shreg_shl;
            mosi_d  = shreg_shl[DW-1];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_SCK_LO: begin
        if (phase_end) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          state_d = ST_SCK_HI;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_HOLD: begin
        if (phase_end) begin
          cnt_d   = '0;
          cs_d    = 1'b1;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      cs_q    <= 1'b1;
      dc_q    <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      cs_q    <= cs_d;
      dc_q    <= dc_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign cs   = cs_q;
  assign dc   = dc_q;
  assign sclk = sclk_q;
  assign mosi = mosi_q;

endmodule

// File: tb/tb_ili_spi_tx.sv
// Bench for ili_spi_tx: two instances (CLK_DIV=2 and CLK_DIV=1) observed by a
// pin-level monitor that reconstructs words the way the panel would see them.
module tb_ili_spi_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst_v;
  logic [1:0]      send_v;
  logic [1:0]      dc_in_v;
  logic [1:0][7:0] data_v;
  wire  [1:0]      busy_w, done_w, cs_w, dc_w, sclk_w, mosi_w;

  ili_spi_tx #(.DW(8), .CLK_DIV(2)) u_dut0 (
    .clk(clk), .rst(rst_v[0]), .send(send_v[0]), .data(data_v[0]), .dc_in(dc_in_v[0]),
    .busy(busy_w[0]), .done(done_w[0]), .cs(cs_w[0]), .dc(dc_w[0]),
    .sclk(sclk_w[0]), .mosi(mosi_w[0])
  );

  ili_spi_tx #(.DW(8), .CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst_v[1]), .send(send_v[1]), .data(data_v[1]), .dc_in(dc_in_v[1]),
    .busy(busy_w[1]), .done(done_w[1]), .cs(cs_w[1]), .dc(dc_w[1]),
    .sclk(sclk_w[1]), .mosi(mosi_w[1])
  );

  int total = 0;
  int bad   = 0;

  // Observations from the last run_cycles call.
  logic [7:0] w_val[$];
  int         w_n[$];
  logic       w_dc[$];
  int         done_at[$];
  int         gaps[$];
  int         busy_cnt, dc_bad, mosi_bad, stray;
  logic       snap_cs, snap_sclk, snap_busy;

  function automatic int cdiv(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  // Word latency from the timing rule: SETUP + (2*DW-1) half periods + HOLD + DONE.
  function automatic int n_lat(input int k);
    return 2 * 8 * cdiv(k) + cdiv(k) + 1;
  endfunction

  function automatic logic [7:0] wv(input int i);
    return (i < w_val.size()) ? w_val[i] : 8'hxx;
  endfunction

  function automatic int wn(input int i);
    return (i < w_n.size()) ? w_n[i] : -1;
  endfunction

  function automatic logic wd(input int i);
    return (i < w_dc.size()) ? w_dc[i] : 1'bx;
  endfunction

  function automatic int dn(input int i);
    return (i < done_at.size()) ? done_at[i] : -1;
  endfunction

  function automatic int gp(input int i);
    return (i < gaps.size()) ? gaps[i] : -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs ncyc cycles on instance k (acceptance edge ends cycle 0), monitoring
  // pins and driving the per-cycle stimulus described by the arguments.
  task automatic run_cycles(input int k, input int ncyc, input int send_until,
                            input int ign_at, input int rst_at, input int resend_at,
                            input logic [7:0] d2, input logic dc2, input bit scramble);
    logic       p_cs, p_sclk, p_mosi, cur_dc;
    logic [7:0] cur_val;
    int         cur_n, hi_run;
    bit         seen;
    w_val.delete(); w_n.delete(); w_dc.delete(); done_at.delete(); gaps.delete();
    busy_cnt = 0; dc_bad = 0; mosi_bad = 0; stray = 0;
    snap_cs = 1'bx; snap_sclk = 1'bx; snap_busy = 1'bx;
    p_cs = cs_w[k]; p_sclk = sclk_w[k]; p_mosi = mosi_w[k];
    cur_dc = 1'b0; cur_val = 8'h00; cur_n = 0; hi_run = 0; seen = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      if (busy_w[k]) busy_cnt++;
      if (done_w[k]) done_at.push_back(c);
      if (c == rst_at + 1) begin
        snap_cs = cs_w[k]; snap_sclk = sclk_w[k]; snap_busy = busy_w[k];
      end
      if (!cs_w[k] && p_cs) begin
        if (seen) gaps.push_back(hi_run);
        seen = 1'b1; cur_val = 8'h00; cur_n = 0; cur_dc = dc_w[k];
      end
      if (cs_w[k]) hi_run++; else hi_run = 0;
      if (!cs_w[k] && dc_w[k] !== cur_dc) dc_bad++;
      if (sclk_w[k] && !p_sclk) begin
        if (!cs_w[k]) begin
          cur_val = {cur_val[6:0], mosi_w[k]};
          cur_n++;
        end else begin
          stray++;
        end
      end
      if (sclk_w[k] && mosi_w[k] !== p_mosi) mosi_bad++;
      if (cs_w[k] && !p_cs) begin
        w_val.push_back(cur_val); w_n.push_back(cur_n); w_dc.push_back(cur_dc);
      end
      p_cs = cs_w[k]; p_sclk = sclk_w[k]; p_mosi = mosi_w[k];
      send_v[k]  = (c < send_until) || (c == ign_at) || (c == rst_at) || (c == resend_at);
      data_v[k]  = d2;
      dc_in_v[k] = dc2;
      if (c == ign_at) data_v[k] = 8'h00;
      if (c == rst_at) data_v[k] = ~d2;
      rst_v[k] = (c == rst_at);
      if (scramble) begin
        data_v[k]  = 8'($urandom);
        dc_in_v[k] = 1'($urandom);
      end
    end
    send_v[k] = 1'b0;
    rst_v[k]  = 1'b0;
  endtask

  // Reset values on both instances, with send asserted during reset.
  task automatic test_reset();
    rst_v = 2'b11; send_v = 2'b11; dc_in_v = 2'b00;
    data_v[0] = 8'hC3; data_v[1] = 8'h3C;
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({cs_w[k], dc_w[k], sclk_w[k], mosi_w[k], busy_w[k], done_w[k]} !== 6'b110000) begin
        bad++;
        $display("FAIL reset_outputs k=%0d: got {cs,dc,sclk,mosi,busy,done}=%b want 110000", k,
                 {cs_w[k], dc_w[k], sclk_w[k], mosi_w[k], busy_w[k], done_w[k]});
      end
    end
    rst_v = 2'b00; send_v = 2'b00;
  endtask

  // One word: bits MSB first at sclk rises, dc, done timing and busy length.
  task automatic test_word(input int k, input logic [7:0] w, input logic dcv, input bit scr);
    int n;
    n = n_lat(k);
    send_v[k] = 1'b1; data_v[k] = w; dc_in_v[k] = dcv;
    run_cycles(k, n + 4, 1, -1, -1, -1, w, dcv, scr);
    total++;
    if (w_val.size() != 1) begin
      bad++; $display("FAIL word_count k=%0d: got %0d want 1", k, w_val.size());
    end
    total++;
    if (wv(0) !== w) begin
      bad++; $display("FAIL word_bits k=%0d: got %h want %h", k, wv(0), w);
    end
    total++;
    if (wn(0) !== 8) begin
      bad++; $display("FAIL sclk_rises k=%0d: got %0d want 8", k, wn(0));
    end
    total++;
    if (wd(0) !== dcv || dc_bad != 0) begin
      bad++; $display("FAIL dc k=%0d: got %b (changes %0d) want %b", k, wd(0), dc_bad, dcv);
    end
    total++;
    if (done_at.size() != 1 || dn(0) != n) begin
      bad++; $display("FAIL done_cycle k=%0d: got %0d (pulses %0d) want %0d", k, dn(0), done_at.size(), n);
    end
    total++;
    if (busy_cnt != n) begin
      bad++; $display("FAIL busy_len k=%0d: got %0d want %0d", k, busy_cnt, n);
    end
    total++;
    if (mosi_bad != 0 || stray != 0) begin
      bad++; $display("FAIL sclk_mosi k=%0d: got mosi_while_high=%0d stray_edges=%0d want 0", k, mosi_bad, stray);
    end
  endtask

  // send held high across two words: second word latched in the IDLE after DONE.
  task automatic test_back_to_back();
    int n;
    n = n_lat(0);
    send_v[0] = 1'b1; data_v[0] = 8'h11; dc_in_v[0] = 1'b0;
    run_cycles(0, 2 * n + 6, n + 2, -1, -1, -1, 8'h22, 1'b0, 1'b0);
    total++;
    if (w_val.size() != 2 || wv(0) !== 8'h11 || wv(1) !== 8'h22) begin
      bad++; $display("FAIL b2b_words: got n=%0d %h %h want 2 11 22", w_val.size(), wv(0), wv(1));
    end
    total++;
    if (wn(0) !== 8 || wn(1) !== 8) begin
      bad++; $display("FAIL b2b_rises: got %0d %0d want 8 8", wn(0), wn(1));
    end
    total++;
    if (gaps.size() != 1 || gp(0) != 2) begin
      bad++; $display("FAIL b2b_cs_gap: got %0d want 2", gp(0));
    end
    total++;
    if (done_at.size() != 2 || dn(0) != n || dn(1) != 2 * n + 1) begin
      bad++; $display("FAIL b2b_done: got %0d %0d want %0d %0d", dn(0), dn(1), n, 2 * n + 1);
    end
    total++;
    if (busy_cnt != 2 * n) begin
      bad++; $display("FAIL b2b_busy: got %0d want %0d", busy_cnt, 2 * n);
    end
  endtask

  // A send pulse mid-transfer is dropped and does not corrupt the word.
  task automatic test_ignored();
    int n;
    n = n_lat(0);
    send_v[0] = 1'b1; data_v[0] = 8'hA5; dc_in_v[0] = 1'b1;
    run_cycles(0, n + 10, 1, 10, -1, -1, 8'hA5, 1'b1, 1'b0);
    total++;
    if (w_val.size() != 1 || wv(0) !== 8'hA5) begin
      bad++; $display("FAIL ignored_words: got n=%0d %h want 1 a5", w_val.size(), wv(0));
    end
    total++;
    if (done_at.size() != 1 || dn(0) != n || busy_cnt != n) begin
      bad++; $display("FAIL ignored_timing: got done=%0d busy=%0d want %0d %0d", dn(0), busy_cnt, n, n);
    end
  endtask

  // Reset in the 4th SCK_HI aborts the word; a new send right after is accepted.
  task automatic test_mid_reset();
    int n, ra;
    n  = n_lat(0);
    ra = 1 + cdiv(0) * 7;
    send_v[0] = 1'b1; data_v[0] = 8'h96; dc_in_v[0] = 1'b0;
    run_cycles(0, ra + 1 + n + 4, 1, -1, ra, ra + 1, 8'h5C, 1'b1, 1'b0);
    total++;
    if ({snap_cs, snap_sclk, snap_busy} !== 3'b100) begin
      bad++; $display("FAIL rst_abort_pins: got {cs,sclk,busy}=%b want 100", {snap_cs, snap_sclk, snap_busy});
    end
    total++;
    if (wn(0) !== 4 || wv(0) !== 8'h09) begin
      bad++; $display("FAIL rst_partial: got %0d bits %h want 4 bits 09", wn(0), wv(0));
    end
    total++;
    if (w_val.size() != 2 || wv(1) !== 8'h5C || wn(1) !== 8 || wd(1) !== 1'b1) begin
      bad++; $display("FAIL rst_resend: got n=%0d %h/%0d dc=%b want 2 5c/8 dc=1", w_val.size(), wv(1), wn(1), wd(1));
    end
    total++;
    if (done_at.size() != 1 || dn(0) != ra + 1 + n) begin
      bad++; $display("FAIL rst_done: got %0d (pulses %0d) want %0d", dn(0), done_at.size(), ra + 1 + n);
    end
    total++;
    if (busy_cnt != ra + n || stray != 0) begin
      bad++; $display("FAIL rst_busy: got busy=%0d stray=%0d want %0d 0", busy_cnt, stray, ra + n);
    end
  endtask

  initial begin
    rst_v = 2'b11; send_v = 2'b00; dc_in_v = 2'b00; data_v = '0;
    test_reset();
    test_word(0, 8'h2A, 1'b0, 1'b0);
    test_word(1, 8'hFF, 1'b1, 1'b0);
    test_back_to_back();
    test_ignored();
    test_mid_reset();
    test_word(0, 8'h3C, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      test_word(i % 2, 8'($urandom), 1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 3)) tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
